// File: rtl/nios_system_debug_mem_arbiter.sv
// Round-robin arbiter giving several CPU debug requesters shared access to one
// single-ported debug memory, with a one-entry request slot per requester and an ack timeout.
module nios_system_debug_mem_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 9,
   parameter int TIMEOUT = 15
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ-1:0]        req_write,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*32-1:0]     req_wdata,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [31:0]               rsp_data,
   output logic                      rsp_err,
   output logic [NUM_REQ-1:0]        overflow,
   input  logic [NUM_REQ-1:0]        ovf_clr,
   output logic                      mem_req,
   output logic                      mem_write,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic [31:0]               mem_wdata,
   input  logic                      mem_ack,
   input  logic [31:0]               mem_rdata,
   output logic                      busy
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = 8;
   localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

   state_t               state_r;
   logic [IDX_W-1:0]     ptr_r;
   logic [IDX_W-1:0]     win_r;
   logic [CNT_W-1:0]     cnt_r;
   logic [NUM_REQ-1:0]   pend_r;
   logic [NUM_REQ-1:0]   ovf_r;
   logic                 slot_write_r [NUM_REQ];
   logic [ADDR_W-1:0]    slot_addr_r  [NUM_REQ];
   logic [31:0]          slot_wdata_r [NUM_REQ];
   logic [NUM_REQ-1:0]   rsp_valid_r;
   logic [31:0]          rsp_data_r;
   logic                 rsp_err_r;
   logic                 mem_req_r;
   logic                 mem_write_r;
   logic [ADDR_W-1:0]    mem_addr_r;
   logic [31:0]          mem_wdata_r;
   logic                 busy_r;

   logic [NUM_REQ-1:0]   free_s;
   logic [NUM_REQ-1:0]   load_s;
   logic [NUM_REQ-1:0]   ovf_set_s;
   logic [IDX_W-1:0]     pick_s;
   logic                 tmo_s;

   // First pending requester found scanning upward from the one after 'last'.
   function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] pend,
                                                 input logic [IDX_W-1:0]   last);
      logic [IDX_W-1:0] pick;
      logic [IDX_W-1:0] idx;
      logic             found;
      pick  = last;
      found = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx   = IDX_W'((int'(last) + k) % NUM_REQ);
         pick  = (!found && pend[idx]) ? idx : pick;
         found = found | pend[idx];
      end
      return pick;
   endfunction

   // Slot acceptance: a slot retiring this cycle counts as free, so retire-then-load needs no overflow.
   always_comb begin
      free_s    = ~pend_r | rsp_valid_r;
      load_s    = req_valid & free_s;
      ovf_set_s = req_valid & ~free_s;
      pick_s    = rr_pick(pend_r, ptr_r);
      tmo_s     = (state_r == WAIT) && (cnt_r == CNT_W'(TIMEOUT - 1));
   end

   // Per-requester request slots and sticky overflow flags (set beats clear).
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pend_r <= '0;
         ovf_r  <= '0;
         for (int i = 0; i < NUM_REQ; i++) begin
            slot_write_r[i] <= 1'b0;
            slot_addr_r[i]  <= '0;
            slot_wdata_r[i] <= 32'd0;
         end
      end else begin
         pend_r <= (pend_r & ~rsp_valid_r) | load_s;
         ovf_r  <= (ovf_r & ~ovf_clr) | ovf_set_s;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (load_s[i]) begin
               slot_write_r[i] <= req_write[i];
               slot_addr_r[i]  <= req_addr[i*ADDR_W +: ADDR_W];
               slot_wdata_r[i] <= req_wdata[i*32 +: 32];
            end
         end
      end
   end

   // Arbitration FSM with registered memory-side and response-side outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r     <= IDLE;
         ptr_r       <= IDX_W'(NUM_REQ - 1);
         win_r       <= '0;
         cnt_r       <= '0;
         rsp_valid_r <= '0;
         rsp_data_r  <= 32'd0;
         rsp_err_r   <= 1'b0;
         mem_req_r   <= 1'b0;
         mem_write_r <= 1'b0;
         mem_addr_r  <= '0;
         mem_wdata_r <= 32'd0;
         busy_r      <= 1'b0;
      end else begin
         rsp_valid_r <= '0;
         rsp_data_r  <= 32'd0;
         rsp_err_r   <= 1'b0;
         mem_req_r   <= 1'b0;
         case (state_r)
            IDLE: begin
               if (|pend_r) begin
                  win_r       <= pick_s;
                  mem_req_r   <= 1'b1;
                  mem_write_r <= slot_write_r[pick_s];
                  mem_addr_r  <= slot_addr_r[pick_s];
                  mem_wdata_r <= slot_wdata_r[pick_s];
                  cnt_r       <= '0;
                  busy_r      <= 1'b1;
                  state_r     <= ISSUE;
               end
            end
            ISSUE, WAIT: begin
               if (mem_ack || tmo_s) begin
                  rsp_valid_r <= ONE << win_r;
                  rsp_err_r   <= ~mem_ack;
                  rsp_data_r  <= (mem_ack && !mem_write_r) ? mem_rdata : 32'd0;
                  mem_write_r <= 1'b0;
                  mem_addr_r  <= '0;
                  mem_wdata_r <= 32'd0;
                  cnt_r       <= '0;
                  state_r     <= RESP;
               end else if (state_r == ISSUE) begin
                  state_r <= WAIT;
               end else begin
                  cnt_r <= cnt_r + 8'd1;
               end
            end
            RESP: begin
               ptr_r   <= win_r;
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign rsp_valid = rsp_valid_r;
   assign rsp_data  = rsp_data_r;
   assign rsp_err   = rsp_err_r;
   assign overflow  = ovf_r;
   assign mem_req   = mem_req_r;
   assign mem_write = mem_write_r;
   assign mem_addr  = mem_addr_r;
   assign mem_wdata = mem_wdata_r;
   assign busy      = busy_r;

endmodule

// File: tb/tb_nios_system_debug_mem_arbiter.sv
// Bench for the debug memory arbiter: vector table of single transactions plus
// hand-written sequences, responses checked through an expected-response queue.
module tb_nios_system_debug_mem_arbiter;

   localparam int NR = 4;
   localparam int AW = 9;

   logic            clk;
   logic            reset_n;
   logic [NR-1:0]   req_valid;
   logic [NR-1:0]   req_write;
   logic [NR*AW-1:0] req_addr;
   logic [NR*32-1:0] req_wdata;
   logic [NR-1:0]   rsp_valid;
   logic [31:0]     rsp_data;
   logic            rsp_err;
   logic [NR-1:0]   overflow;
   logic [NR-1:0]   ovf_clr;
   logic            mem_req;
   logic            mem_write;
   logic [AW-1:0]   mem_addr;
   logic [31:0]     mem_wdata;
   logic            mem_ack;
   logic [31:0]     mem_rdata;
   logic            busy;

   nios_system_debug_mem_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .TIMEOUT(15)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .overflow(overflow), .ovf_clr(ovf_clr),
      .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
   );

   typedef struct {
      logic [3:0]  vld;
      logic [31:0] data;
      logic        err;
   } exp_t;

   typedef struct {
      int          idx;
      logic        wr;
      logic [8:0]  addr;
      logic [31:0] wdata;
      int          dly;
      logic [31:0] rdata;
      logic [31:0] edata;
      logic        eerr;
      int          elat;
   } vec_t;

   exp_t        exp_q [$];
   logic [8:0]  iss_addr_q [$];
   logic        iss_wr_q [$];
   logic [31:0] iss_wd_q [$];
   vec_t        vt [6];

   int          n_checks = 0;
   int          n_fail = 0;
   int          ack_delay = 1;
   logic [31:0] cur_rdata = 32'd0;
   bit          chk_stable = 1'b1;
   logic [8:0]  r_addr;
   logic        r_wr;
   logic [31:0] r_wd;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] onehot(input int i);
      return 4'b0001 << i;
   endfunction

   task automatic set_slot(input int i, input logic wr, input logic [8:0] a, input logic [31:0] d);
      req_write[i]         = wr;
      req_addr[i*AW +: AW] = a;
      req_wdata[i*32 +: 32] = d;
   endtask

   task automatic push_exp(input logic [3:0] v, input logic [31:0] d, input logic e);
      exp_t x;
      x.vld = v; x.data = d; x.err = e;
      exp_q.push_back(x);
   endtask

   task automatic wait_idle();
      int c = 0;
      do begin
         @(negedge clk);
         c++;
      end while ((exp_q.size() != 0 || busy) && c < 300);
      check("idle_bound_expired", 64'(c >= 300), 64'(0));
      repeat (2) @(negedge clk);
   endtask

   task automatic check_issue(input logic [8:0] a, input logic w, input logic [31:0] d);
      if (iss_addr_q.size() == 0) begin
         check("issue_logged", 64'(0), 64'(1));
      end else begin
         check("issued_addr", 64'(iss_addr_q.pop_front()), 64'(a));
         check("issued_write", 64'(iss_wr_q.pop_front()), 64'(w));
         check("issued_wdata", 64'(iss_wd_q.pop_front()), 64'(d));
      end
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
      check({tag, "_rsp_data"}, 64'(rsp_data), 64'(0));
      check({tag, "_rsp_err"}, 64'(rsp_err), 64'(0));
      check({tag, "_mem_req"}, 64'(mem_req), 64'(0));
      check({tag, "_mem_write"}, 64'(mem_write), 64'(0));
      check({tag, "_mem_addr"}, 64'(mem_addr), 64'(0));
      check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'(0));
      check({tag, "_busy"}, 64'(busy), 64'(0));
   endtask

   // Memory model: logs each issued request, checks the held bus in WAIT, acks after ack_delay (<0: never).
   always begin
      @(negedge clk);
      if (reset_n && mem_req) begin
         r_addr = mem_addr; r_wr = mem_write; r_wd = mem_wdata;
         iss_addr_q.push_back(r_addr);
         iss_wr_q.push_back(r_wr);
         iss_wd_q.push_back(r_wd);
         if (ack_delay >= 0) begin
            for (int k = 0; k < ack_delay; k++) begin
               @(negedge clk);
               if (chk_stable) begin
                  check("mem_req_low_in_wait", 64'(mem_req), 64'(0));
                  check("mem_addr_held", 64'(mem_addr), 64'(r_addr));
                  check("mem_write_held", 64'(mem_write), 64'(r_wr));
                  check("mem_wdata_held", 64'(mem_wdata), 64'(r_wd));
               end
            end
            mem_ack = 1'b1; mem_rdata = cur_rdata;
            @(negedge clk);
            mem_ack = 1'b0; mem_rdata = 32'd0;
         end
      end
   end

   // Response monitor: every completion must match the head of the expected queue.
   always @(negedge clk) begin
      exp_t e;
      if (rsp_valid != 4'b0000) begin
         if (exp_q.size() == 0) begin
            check("unexpected_rsp_valid", 64'(rsp_valid), 64'(0));
         end else begin
            e = exp_q.pop_front();
            check("rsp_valid", 64'(rsp_valid), 64'(e.vld));
            check("rsp_data", 64'(rsp_data), 64'(e.data));
            check("rsp_err", 64'(rsp_err), 64'(e.err));
         end
      end else begin
         check("rsp_zero_when_idle", 64'({rsp_data, rsp_err}), 64'(0));
      end
   end

   initial begin
      int lat;
      int b;
      vt[0] = '{0, 1'b0, 9'h005, 32'h0,        1, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 4};
      vt[1] = '{1, 1'b1, 9'h1FF, 32'h12345678, 1, 32'hCAFEF00D, 32'h0,        1'b0, 4};
      vt[2] = '{2, 1'b0, 9'h000, 32'h0,        0, 32'h00001111, 32'h00001111, 1'b0, 3};
      vt[3] = '{3, 1'b0, 9'h100, 32'h0,       15, 32'h5555AAAA, 32'h5555AAAA, 1'b0, 18};
      vt[4] = '{0, 1'b1, 9'h0AA, 32'h9ABCDEF0, -1, 32'hFFFFFFFF, 32'h0,        1'b1, 18};
      vt[5] = '{3, 1'b0, 9'h033, 32'h0,       -1, 32'h87654321, 32'h0,        1'b1, 18};

      reset_n = 1'b0; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
      ovf_clr = '0; mem_ack = 1'b0; mem_rdata = 32'd0;
      repeat (3) @(negedge clk);
      check_quiet("reset");
      check("reset_overflow", 64'(overflow), 64'(0));
      reset_n = 1'b1;
      @(negedge clk);
      check_quiet("after_reset");

      // Single transactions from the vector table, with request-to-response latency.
      for (int v = 0; v < 6; v++) begin
         ack_delay = vt[v].dly; cur_rdata = vt[v].rdata;
         @(negedge clk);
         set_slot(vt[v].idx, vt[v].wr, vt[v].addr, vt[v].wdata);
         req_valid = onehot(vt[v].idx);
         push_exp(onehot(vt[v].idx), vt[v].edata, vt[v].eerr);
         lat = 0;
         do begin
            @(negedge clk);
            lat++;
            if (lat == 1) req_valid = '0;
         end while (rsp_valid == 4'b0000 && lat < 60);
         check("latency", 64'(lat), 64'(vt[v].elat));
         wait_idle();
         check_issue(vt[v].addr, vt[v].wr, vt[v].wdata);
      end

      // Fairness: all four at once, then 0+2 from pointer 3, then 0+3 from pointer 2.
      ack_delay = 1; cur_rdata = 32'h11223344;
      @(negedge clk);
      for (int i = 0; i < NR; i++) set_slot(i, 1'b0, 9'(9'h010 + i), 32'h0);
      req_valid = 4'b1111;
      for (int i = 0; i < NR; i++) push_exp(onehot(i), 32'h11223344, 1'b0);
      @(negedge clk);
      req_valid = '0;
      wait_idle();
      for (int i = 0; i < NR; i++) check_issue(9'(9'h010 + i), 1'b0, 32'h0);

      set_slot(0, 1'b0, 9'h020, 32'h0); set_slot(2, 1'b0, 9'h022, 32'h0);
      req_valid = 4'b0101;
      push_exp(4'b0001, 32'h11223344, 1'b0); push_exp(4'b0100, 32'h11223344, 1'b0);
      @(negedge clk);
      req_valid = '0;
      wait_idle();
      check_issue(9'h020, 1'b0, 32'h0);
      check_issue(9'h022, 1'b0, 32'h0);

      set_slot(0, 1'b0, 9'h030, 32'h0); set_slot(3, 1'b0, 9'h033, 32'h0);
      req_valid = 4'b1001;
      push_exp(4'b1000, 32'h11223344, 1'b0); push_exp(4'b0001, 32'h11223344, 1'b0);
      @(negedge clk);
      req_valid = '0;
      wait_idle();
      check_issue(9'h033, 1'b0, 32'h0);
      check_issue(9'h030, 1'b0, 32'h0);

      // Timeout back-to-back: pointer is 0, so requester 1 goes first, then 0 is issued.
      ack_delay = -1;
      set_slot(0, 1'b1, 9'h0F0, 32'hAAAA5555); set_slot(1, 1'b0, 9'h0F1, 32'h0);
      req_valid = 4'b0011;
      push_exp(4'b0010, 32'h0, 1'b1); push_exp(4'b0001, 32'h0, 1'b1);
      @(negedge clk);
      req_valid = '0;
      wait_idle();
      check_issue(9'h0F1, 1'b0, 32'h0);
      check_issue(9'h0F0, 1'b1, 32'hAAAA5555);

      // Overflow: two extra strobes while pending, the second coinciding with ovf_clr.
      ack_delay = 3; cur_rdata = 32'h0000BEEF;
      set_slot(1, 1'b0, 9'h011, 32'h0);
      req_valid = 4'b0010;
      push_exp(4'b0010, 32'h0000BEEF, 1'b0);
      @(negedge clk);
      set_slot(1, 1'b0, 9'h022, 32'h0);
      @(negedge clk);
      check("overflow_set", 64'(overflow), 64'(4'b0010));
      set_slot(1, 1'b0, 9'h033, 32'h0);
      ovf_clr = 4'b0010;
      @(negedge clk);
      req_valid = '0; ovf_clr = '0;
      check("overflow_set_beats_clr", 64'(overflow), 64'(4'b0010));
      wait_idle();
      check_issue(9'h011, 1'b0, 32'h0);
      check("only_first_issued", 64'(iss_addr_q.size()), 64'(0));
      ovf_clr = 4'b0010;
      @(negedge clk);
      ovf_clr = '0;
      check("overflow_cleared", 64'(overflow), 64'(0));

      // Retire-and-load on requester 2.
      ack_delay = 1; cur_rdata = 32'h0A0A0A0A;
      set_slot(2, 1'b0, 9'h0A0, 32'h0);
      req_valid = 4'b0100;
      push_exp(4'b0100, 32'h0A0A0A0A, 1'b0);
      @(negedge clk);
      req_valid = '0;
      b = 0;
      while (rsp_valid[2] !== 1'b1 && b < 40) begin
         @(negedge clk);
         b++;
      end
      check("retire_rsp_seen", 64'(rsp_valid), 64'(4'b0100));
      set_slot(2, 1'b1, 9'h0A1, 32'h77778888);
      req_valid = 4'b0100;
      push_exp(4'b0100, 32'h0, 1'b0);
      @(negedge clk);
      req_valid = '0;
      wait_idle();
      check("retire_load_no_overflow", 64'(overflow), 64'(0));
      check_issue(9'h0A0, 1'b0, 32'h0);
      check_issue(9'h0A1, 1'b1, 32'h77778888);

      // Reset during WAIT; the memory acks only after reset is released.
      ack_delay = 6; chk_stable = 1'b0;
      set_slot(1, 1'b0, 9'h044, 32'h0);
      req_valid = 4'b0010;
      @(negedge clk);
      req_valid = '0;
      b = 0;
      while (!mem_req && b < 20) begin
         @(negedge clk);
         b++;
      end
      check("mem_req_seen", 64'(mem_req), 64'(1));
      repeat (2) @(negedge clk);
      reset_n = 1'b0;
      #1;
      check_quiet("in_reset");
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (12) @(negedge clk);
      check_quiet("after_late_ack");
      check("no_rsp_queued", 64'(exp_q.size()), 64'(0));
      iss_addr_q.delete(); iss_wr_q.delete(); iss_wd_q.delete();
      chk_stable = 1'b1;

      // Normal operation after reset.
      ack_delay = 1; cur_rdata = 32'h0BADF00D;
      set_slot(1, 1'b0, 9'h077, 32'h0);
      req_valid = 4'b0010;
      push_exp(4'b0010, 32'h0BADF00D, 1'b0);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         if (lat == 1) req_valid = '0;
      end while (rsp_valid == 4'b0000 && lat < 60);
      check("post_reset_latency", 64'(lat), 64'(4));
      wait_idle();
      check_issue(9'h077, 1'b0, 32'h0);

      check("final_exp_queue_empty", 64'(exp_q.size()), 64'(0));
      check("final_issue_log_empty", 64'(iss_addr_q.size()), 64'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_time_limit: got expired required finish");
      $fatal(1);
   end

endmodule

// File: doc/nios_system_debug_mem_arbiter.md
NIOS_SYSTEM_DEBUG_MEM_ARBITER -- requirements
Module: nios_system_debug_mem_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning number of CPU debug requesters (2..8).
REQ-002 SHALL have parameter ADDR_W, default 9, meaning shared on-chip debug memory word-address width.
REQ-003 SHALL have parameter TIMEOUT, default 15, meaning the maximum number of cycles to wait for mem_ack (1..255).
REQ-004 SHALL have port clk  input  1  the single system clock; all logic is clocked on its rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port req_valid  input  NUM_REQ  one-cycle request strobe per requester (take_action style).
REQ-007 SHALL have port req_write  input  NUM_REQ  1=write, 0=read; sampled with req_valid.
REQ-008 SHALL have port req_addr  input  NUM_REQ*ADDR_W  flattened; slice i belongs to requester i.
REQ-009 SHALL have port req_wdata  input  NUM_REQ*32  flattened write data.
REQ-010 SHALL have port rsp_valid  output  NUM_REQ  one-hot, one-cycle completion strobe.
REQ-011 SHALL have port rsp_data  output  32  read data (or 0 for writes/errors), valid with rsp_valid.
REQ-012 SHALL have port rsp_err  output  1  timeout indication, valid with rsp_valid.
REQ-013 SHALL have port overflow  output  NUM_REQ  sticky flag: request dropped because the slot was already pending.
REQ-014 SHALL have port ovf_clr  input  NUM_REQ  synchronous clear of the overflow bits.
REQ-015 SHALL have ports mem_req (o,1), mem_write (o,1), mem_addr (o,ADDR_W), mem_wdata (o,32), mem_ack (i,1), mem_rdata (i,32) to the shared single-ported debug memory.
REQ-016 SHALL have port busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-017 SHALL hold, per requester, a one-entry slot (pending, write, addr, wdata) loaded when req_valid[i] is high and the slot is empty.
REQ-018 SHALL, when req_valid[i] is high while slot i is pending, drop the new request, keep the old one, and set overflow[i].
REQ-019 SHALL accept a new request into slot i in the same cycle that slot i is retired by rsp_valid[i] (retire-then-load, no overflow).
REQ-020 SHALL give ovf_clr[i] priority below a same-cycle set: a simultaneous overflow event leaves overflow[i]=1.
REQ-021 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-022 SHALL in IDLE, if any slot is pending, select the winner by round-robin starting at the index after the last granted requester (initial pointer = NUM_REQ-1, so requester 0 wins first), then go to ISSUE.
REQ-023 SHALL in ISSUE drive mem_req=1 with the winner's write/addr/wdata for exactly one cycle, then go to WAIT.
REQ-024 SHALL hold mem_write/mem_addr/mem_wdata stable from ISSUE until leaving WAIT; mem_req is low in WAIT.
REQ-025 SHALL in WAIT capture mem_rdata (reads) on mem_ack=1 and go to RESP; mem_ack in ISSUE is accepted likewise (zero-wait memory).
REQ-026 SHALL in WAIT count cycles; on reaching TIMEOUT without mem_ack, go to RESP with rsp_err=1 and rsp_data=0.
REQ-027 SHALL in RESP assert rsp_valid[winner] for one cycle, clear the winner's pending bit, update the round-robin pointer to the winner, and return to IDLE.
REQ-028 SHALL ignore mem_ack outside ISSUE/WAIT.
REQ-029 SHALL give a request-to-rsp_valid latency of 4 cycles for a single request with mem_ack in the cycle after mem_req (load, IDLE->ISSUE, WAIT, RESP).
REQ-030 SHALL drive rsp_data=0 for writes and rsp_valid/rsp_data/rsp_err =0 outside RESP.

Reset
REQ-031 SHALL on reset_n low immediately clear all slots, overflow, rsp_valid, rsp_data, rsp_err, mem_req, mem_write, mem_addr, mem_wdata, busy, timeout counter, set the FSM to IDLE and the pointer to NUM_REQ-1.
REQ-032 SHALL, on reset asserted mid-transaction, abandon the transaction without issuing rsp_valid; a late mem_ack after reset release is ignored.

Verification
REQ-033 Single read: req_valid[0], addr=0x005, mem_ack one cycle after mem_req with rdata=0xDEADBEEF -> rsp_valid=4'b0001, rsp_data=0xDEADBEEF, rsp_err=0, 4 cycles after strobe.
REQ-034 Fairness: req_valid=4'b1111 in one cycle -> grants in order 0,1,2,3; then re-request 0 and 2 -> order 2? no: pointer=3 so order 0,2.
REQ-035 Overflow: req_valid[1] twice while slot 1 pending -> overflow[1]=1, only first request's addr reaches mem_addr; ovf_clr[1] -> overflow[1]=0.
REQ-036 Timeout: TIMEOUT=15, mem_ack never asserted -> rsp_valid for winner with rsp_err=1, rsp_data=0, 15 WAIT cycles after ISSUE; next pending request then issued.
REQ-037 Retire-and-load: req_valid[2] in the same cycle as rsp_valid[2] -> new request accepted, overflow[2]=0, issued next.
REQ-038 Reset mid-WAIT: reset_n low during WAIT, mem_ack after release -> no rsp_valid, all outputs 0, busy=0.
